// File: rtl/decode_stage_hz.sv
// RISC-V decode stage B->C: decode, immediate, regfile read with bypass,
// load-use hazard bubble, stall/flush, illegal flag, RV32E mode.
module decode_stage_hz #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter bit BYPASS_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           instr_b,
  input  logic                  valid_b,
  input  logic [DATA_WIDTH-1:0] pc_b,
  input  logic [DATA_WIDTH-1:0] pc_plus4_b,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [4:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  hazard_b,
  output logic                  valid_c,
  output logic                  reg_write_c,
  output logic                  mem_write_c,
  output logic                  jump_c,
  output logic                  branch_c,
  output logic                  link_reg_ctrl_c,
  output logic                  illegal_c,
  output logic [1:0]            alu_src_c,
  output logic [1:0]            result_src_c,
  output logic [1:0]            alu_op_c,
  output logic [DATA_WIDTH-1:0] imm_ext_c,
  output logic [DATA_WIDTH-1:0] rdata1_c,
  output logic [DATA_WIDTH-1:0] rdata2_c,
  output logic [DATA_WIDTH-1:0] pc_c,
  output logic [DATA_WIDTH-1:0] pc_plus4_c,
  output logic [4:0]            rd_c,
  output logic [4:0]            rs1_c,
  output logic [4:0]            rs2_c,
  output logic [6:0]            funct7_c,
  output logic [2:0]            funct3_c
);

  localparam int AW = $clog2(REG_COUNT);
  localparam logic [5:0] RC = 6'(REG_COUNT);
  localparam bit RV32E = (REG_COUNT == 16);

  logic [6:0] opc;
  logic [4:0] rs1, rs2, rd;
  assign opc = instr_b[6:0];
  assign rd  = instr_b[11:7];
  assign rs1 = instr_b[19:15];
  assign rs2 = instr_b[24:20];

  logic is_load, is_store, is_branch, is_jal, is_jalr;
  logic is_op, is_opimm, is_lui, is_auipc, known;
  assign is_load   = opc == 7'b0000011;
  assign is_store  = opc == 7'b0100011;
  assign is_branch = opc == 7'b1100011;
  assign is_jal    = opc == 7'b1101111;
  assign is_jalr   = opc == 7'b1100111;
  assign is_op     = opc == 7'b0110011;
  assign is_opimm  = opc == 7'b0010011;
  assign is_lui    = opc == 7'b0110111;
  assign is_auipc  = opc == 7'b0010111;
  assign known = is_load | is_store | is_branch | is_jal | is_jalr
               | is_op | is_opimm | is_lui | is_auipc;

  logic rs1_use, rs2_use, rd_use, e_bad, illegal;
  assign rs1_use = is_op | is_opimm | is_load | is_store
                 | is_branch | is_jalr;
  assign rs2_use = is_op | is_store | is_branch;
  assign rd_use  = is_load | is_op | is_opimm | is_jal
                 | is_jalr | is_lui | is_auipc;
  assign e_bad = RV32E & ((rs1_use & rs1[4]) | (rs2_use & rs2[4])
                        | (rd_use & rd[4]));
  assign illegal = ~known | e_bad;

  logic [31:0] imm32;
  logic [DATA_WIDTH-1:0] imm;
  always_comb begin
    imm32 = '0;
    unique case (1'b1)
      is_load, is_opimm, is_jalr:
        imm32 = {{20{instr_b[31]}}, instr_b[31:20]};
      is_store:
        imm32 = {{20{instr_b[31]}}, instr_b[31:25], instr_b[11:7]};
      is_branch:
        imm32 = {{19{instr_b[31]}}, instr_b[31], instr_b[7],
                 instr_b[30:25], instr_b[11:8], 1'b0};
      is_lui, is_auipc:
        imm32 = {instr_b[31:12], 12'b0};
      is_jal:
        imm32 = {{11{instr_b[31]}}, instr_b[31], instr_b[19:12],
                 instr_b[20], instr_b[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end
  assign imm = {{(DATA_WIDTH-31){imm32[31]}}, imm32[30:0]};

  logic [1:0] result_src, alu_src, alu_op;
  always_comb begin
    result_src = 2'b00;
    alu_op     = 2'b00;
    if (is_load) result_src = 2'b01;
    if (is_jal | is_jalr) result_src = 2'b10;
    if (is_lui) result_src = 2'b11;
    if (is_op | is_opimm) alu_op = 2'b01;
    if (is_load | is_store | is_auipc | is_jalr) alu_op = 2'b10;
    if (is_branch) alu_op = 2'b11;
  end
  assign alu_src = {is_auipc,
                    is_load | is_store | is_opimm | is_auipc | is_jalr};

  logic [DATA_WIDTH-1:0] rf [REG_COUNT];
  logic wr_ok;
  assign wr_ok = wr_en && wr_addr != '0 && {1'b0, wr_addr} < RC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
    end else if (wr_ok) begin
      rf[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  logic [DATA_WIDTH-1:0] rdata1, rdata2;
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (rs1 != '0 && {1'b0, rs1} < RC)
      rdata1 = (BYPASS_EN && wr_en && wr_addr == rs1)
             ? wr_data : rf[rs1[AW-1:0]];
    if (rs2 != '0 && {1'b0, rs2} < RC)
      rdata2 = (BYPASS_EN && wr_en && wr_addr == rs2)
             ? wr_data : rf[rs2[AW-1:0]];
  end

  assign hazard_b = valid_b & valid_c & (result_src_c == 2'b01)
                  & (rd_c != '0)
                  & ((rs1_use & (rs1 == rd_c)) | (rs2_use & (rs2 == rd_c)));

  logic ok;
  assign ok = valid_b & ~illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_c         <= 1'b0;
      reg_write_c     <= 1'b0;
      mem_write_c     <= 1'b0;
      jump_c          <= 1'b0;
      branch_c        <= 1'b0;
      link_reg_ctrl_c <= 1'b0;
      illegal_c       <= 1'b0;
      alu_src_c       <= '0;
      result_src_c    <= '0;
      alu_op_c        <= '0;
      imm_ext_c       <= '0;
      rdata1_c        <= '0;
      rdata2_c        <= '0;
      pc_c            <= '0;
      pc_plus4_c      <= '0;
      rd_c            <= '0;
      rs1_c           <= '0;
      rs2_c           <= '0;
      funct7_c        <= '0;
      funct3_c        <= '0;
    end else if (flush || (!stall && hazard_b)) begin
      valid_c         <= 1'b0;
      reg_write_c     <= 1'b0;
      mem_write_c     <= 1'b0;
      jump_c          <= 1'b0;
      branch_c        <= 1'b0;
      link_reg_ctrl_c <= 1'b0;
      illegal_c       <= 1'b0;
    end else if (stall) begin
      // held operands track writes so they are current on release
      if (wr_ok && wr_addr == rs1_c) rdata1_c <= wr_data;
      if (wr_ok && wr_addr == rs2_c) rdata2_c <= wr_data;
    end else begin
      valid_c         <= valid_b;
      reg_write_c     <= ok & rd_use;
      mem_write_c     <= ok & is_store;
      jump_c          <= ok & (is_jal | is_jalr);
      branch_c        <= ok & is_branch;
      link_reg_ctrl_c <= valid_b & is_jalr;
      illegal_c       <= valid_b & illegal;
      alu_src_c       <= valid_b ? alu_src : 2'b00;
      result_src_c    <= valid_b ? result_src : 2'b00;
      alu_op_c        <= valid_b ? alu_op : 2'b00;
      imm_ext_c       <= imm;
      rdata1_c        <= rdata1;
      rdata2_c        <= rdata2;
      pc_c            <= pc_b;
      pc_plus4_c      <= pc_plus4_b;
      rd_c            <= rd;
      rs1_c           <= rs1;
      rs2_c           <= rs2;
      funct7_c        <= instr_b[31:25];
      funct3_c        <= instr_b[14:12];
    end
  end

endmodule

// File: tb/tb_decode_stage_hz.sv
// Directed bench for decode_stage_hz: three variants (default,
// no bypass, RV32E) share stimulus; expected values go through a queue.
module tb_decode_stage_hz;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] instr_b = '0;
  logic valid_b = 1'b0;
  logic [31:0] pc_b = '0;
  logic [31:0] pc_plus4_b = '0;
  logic stall = 1'b0;
  logic flush = 1'b0;
  logic wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  logic [2:0] hz, vc, rw, mw, jp, br, lk, il;
  logic [1:0] asrc [3];
  logic [1:0] rsrc [3];
  logic [1:0] aop [3];
  logic [31:0] imm [3];
  logic [31:0] rd1 [3];
  logic [31:0] rd2 [3];
  logic [31:0] pcc [3];
  logic [31:0] pc4 [3];
  logic [4:0] rdc [3];
  logic [4:0] rs1c [3];
  logic [4:0] rs2c [3];
  logic [6:0] f7 [3];
  logic [2:0] f3 [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    decode_stage_hz #(
      .DATA_WIDTH(32),
      .REG_COUNT (g == 2 ? 16 : 32),
      .BYPASS_EN (g == 1 ? 1'b0 : 1'b1)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .instr_b(instr_b), .valid_b(valid_b),
      .pc_b(pc_b), .pc_plus4_b(pc_plus4_b),
      .stall(stall), .flush(flush),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .hazard_b(hz[g]), .valid_c(vc[g]),
      .reg_write_c(rw[g]), .mem_write_c(mw[g]),
      .jump_c(jp[g]), .branch_c(br[g]),
      .link_reg_ctrl_c(lk[g]), .illegal_c(il[g]),
      .alu_src_c(asrc[g]), .result_src_c(rsrc[g]), .alu_op_c(aop[g]),
      .imm_ext_c(imm[g]), .rdata1_c(rd1[g]), .rdata2_c(rd2[g]),
      .pc_c(pcc[g]), .pc_plus4_c(pc4[g]),
      .rd_c(rdc[g]), .rs1_c(rs1c[g]), .rs2_c(rs2c[g]),
      .funct7_c(f7[g]), .funct3_c(f3[g])
    );
  end

  localparam int S_VALID = 0, S_IMM = 1, S_RW = 2, S_ASRC = 3;
  localparam int S_AOP = 4, S_RD = 5, S_RD1 = 6, S_RD2 = 7;
  localparam int S_NB1 = 8, S_NB2 = 9, S_ILL = 10, S_MW = 11;
  localparam int S_JMP = 12, S_BR = 13, S_EILL = 14, S_ERW = 15;
  localparam int S_HZ = 16, S_PC = 17, S_RSRC = 18, S_RS1 = 19;
  localparam int S_PC4 = 20;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_VALID: return 32'(vc[0]);
      S_IMM:   return imm[0];
      S_RW:    return 32'(rw[0]);
      S_ASRC:  return 32'(asrc[0]);
      S_AOP:   return 32'(aop[0]);
      S_RD:    return 32'(rdc[0]);
      S_RD1:   return rd1[0];
      S_RD2:   return rd2[0];
      S_NB1:   return rd1[1];
      S_NB2:   return rd2[1];
      S_ILL:   return 32'(il[0]);
      S_MW:    return 32'(mw[0]);
      S_JMP:   return 32'(jp[0]);
      S_BR:    return 32'(br[0]);
      S_EILL:  return 32'(il[2]);
      S_ERW:   return 32'(rw[2]);
      S_HZ:    return 32'(hz[0]);
      S_PC:    return pcc[0];
      S_RSRC:  return 32'(rsrc[0]);
      S_RS1:   return 32'(rs1c[0]);
      S_PC4:   return pc4[0];
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_v(input string tag, input int sel,
                          input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sel);
      checks++;
      assert (o === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    drain();
  endtask

  task automatic drive(input logic [31:0] i, input logic v);
    instr_b = i;
    valid_b = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    expect_v("rst_valid", S_VALID, 32'h0);
    expect_v("rst_imm", S_IMM, 32'h0);
    expect_v("rst_rdata1", S_RD1, 32'h0);
    expect_v("rst_rd", S_RD, 32'h0);
    drain();
    rst_n = 1'b1;

    // addi x5,x0,-1
    drive(32'hFFF00293, 1'b1);
    pc_b = 32'h100;
    pc_plus4_b = 32'h104;
    expect_v("addi_valid", S_VALID, 32'h1);
    expect_v("addi_imm", S_IMM, 32'hFFFF_FFFF);
    expect_v("addi_rw", S_RW, 32'h1);
    expect_v("addi_asrc", S_ASRC, 32'h1);
    expect_v("addi_aop", S_AOP, 32'h1);
    expect_v("addi_rd", S_RD, 32'd5);
    expect_v("addi_pc", S_PC, 32'h100);
    expect_v("addi_pc4", S_PC4, 32'h104);
    expect_v("addi_ill", S_ILL, 32'h0);
    tick();

    // add x4,x3,x3 while x3 <= 0x1234
    drive(32'h00318233, 1'b1);
    wr_en = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'h1234;
    expect_v("byp_rdata1", S_RD1, 32'h1234);
    expect_v("byp_rdata2", S_RD2, 32'h1234);
    expect_v("nobyp_rdata1", S_NB1, 32'h0);
    expect_v("nobyp_rdata2", S_NB2, 32'h0);
    tick();
    wr_en = 1'b0;
    expect_v("nobyp_next_rdata1", S_NB1, 32'h1234);
    tick();

    // x0 write is discarded: add x4,x0,x0
    drive(32'h00000233, 1'b1);
    wr_en = 1'b1;
    wr_addr = 5'd0;
    wr_data = 32'hFFFF;
    expect_v("x0_byp_rdata1", S_RD1, 32'h0);
    tick();
    wr_en = 1'b0;
    expect_v("x0_rdata1", S_RD1, 32'h0);
    tick();

    // load-use: lw x7,0(x1) then add x8,x7,x2
    drive(32'h0000A383, 1'b1);
    expect_v("lw_rsrc", S_RSRC, 32'h1);
    tick();
    drive(32'h00210433, 1'b1);
    #1;
    expect_v("nodep_hazard", S_HZ, 32'h0);
    drain();
    drive(32'h00238433, 1'b1);
    #1;
    expect_v("dep_hazard", S_HZ, 32'h1);
    drain();
    expect_v("bubble_valid", S_VALID, 32'h0);
    expect_v("bubble_rw", S_RW, 32'h0);
    expect_v("bubble_hazard", S_HZ, 32'h0);
    tick();
    expect_v("after_bubble_valid", S_VALID, 32'h1);
    expect_v("after_bubble_rd", S_RD, 32'd8);
    tick();

    // stall with x6 written mid-stall: add x9,x6,x0
    drive(32'h000304B3, 1'b1);
    expect_v("pre_stall_rs1", S_RS1, 32'd6);
    tick();
    stall = 1'b1;
    drive(32'hFFF00293, 1'b1);
    expect_v("stall1_rd", S_RD, 32'd9);
    expect_v("stall1_rdata1", S_RD1, 32'h0);
    tick();
    wr_en = 1'b1;
    wr_addr = 5'd6;
    wr_data = 32'hABCD;
    expect_v("stall2_rdata1", S_RD1, 32'hABCD);
    expect_v("stall2_imm", S_IMM, 32'h0);
    expect_v("stall2_rd", S_RD, 32'd9);
    tick();
    wr_en = 1'b0;
    expect_v("stall3_rdata1", S_RD1, 32'hABCD);
    expect_v("stall3_valid", S_VALID, 32'h1);
    tick();
    flush = 1'b1;
    expect_v("stall_flush_valid", S_VALID, 32'h0);
    expect_v("stall_flush_rw", S_RW, 32'h0);
    tick();
    stall = 1'b0;
    flush = 1'b0;

    // sw x2,-4(x1)
    drive(32'hFE20AE23, 1'b1);
    expect_v("sw_imm", S_IMM, 32'hFFFF_FFFC);
    expect_v("sw_mw", S_MW, 32'h1);
    expect_v("sw_rw", S_RW, 32'h0);
    tick();

    // lui x5,0x12345
    drive(32'h123452B7, 1'b1);
    expect_v("lui_imm", S_IMM, 32'h1234_5000);
    expect_v("lui_rsrc", S_RSRC, 32'h3);
    tick();

    // unknown opcode
    drive(32'h0000007F, 1'b1);
    expect_v("ill_flag", S_ILL, 32'h1);
    expect_v("ill_valid", S_VALID, 32'h1);
    expect_v("ill_rw", S_RW, 32'h0);
    expect_v("ill_mw", S_MW, 32'h0);
    expect_v("ill_jmp", S_JMP, 32'h0);
    expect_v("ill_br", S_BR, 32'h0);
    tick();

    // add x17,x1,x2: fine on RV32I, illegal on RV32E
    drive(32'h002088B3, 1'b1);
    expect_v("i_x17_ill", S_ILL, 32'h0);
    expect_v("i_x17_rw", S_RW, 32'h1);
    expect_v("e_x17_ill", S_EILL, 32'h1);
    expect_v("e_x17_rw", S_ERW, 32'h0);
    tick();

    // async reset mid-cycle
    drive(32'hFFF00293, 1'b1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    expect_v("arst_valid", S_VALID, 32'h0);
    expect_v("arst_rw", S_RW, 32'h0);
    expect_v("arst_rd", S_RD, 32'h0);
    expect_v("arst_imm", S_IMM, 32'h0);
    drain();
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    drive(32'h00318233, 1'b1);
    expect_v("arst_rf_x3", S_RD1, 32'h0);
    expect_v("arst_valid_back", S_VALID, 32'h1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage_hz.md
Name: decode_stage_hz

Overview:
- Parametrised next-generation RISC-V decode (B->C) pipeline stage.
- Decodes the instruction, extends the immediate, and reads the register file (x0 hardwired zero) with write-through bypass.
- Registers results into the C stage with a valid bit, plus stall and flush handling, load-use hazard detection with bubble insertion, illegal-opcode flagging, and RV32E mode.

Parameters:
DATA_WIDTH, 32, datapath/register width (>=32)
REG_COUNT, 32, architectural registers; 32 (RV32I) or 16 (RV32E)
BYPASS_EN, 1, 1 = same-cycle write-through from the write port to B-stage reads

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
instr_b  in  32  instruction in B
valid_b  in  1  B holds a real instruction
pc_b / pc_plus4_b  in  DATA_WIDTH  PC and PC+4 of B instruction
stall  in  1  downstream hold request
flush  in  1  kill B instruction (branch/jump redirect)
wr_en / wr_addr / wr_data  in  1/5/DATA_WIDTH  register write port
hazard_b  out  1  combinational load-use detect; upstream must hold B
valid_c  out  1  C holds a real instruction
reg_write_c, mem_write_c, jump_c, branch_c, link_reg_ctrl_c, illegal_c  out  1 each  control
alu_src_c / result_src_c / alu_op_c  out  2 each  control
imm_ext_c, rdata1_c, rdata2_c, pc_c, pc_plus4_c  out  DATA_WIDTH  data
rd_c, rs1_c, rs2_c  out  5  register addresses
funct7_c / funct3_c  out  7/3  function fields

Behaviour:
- Reset: every C output is 0. The register file clears to 0 asynchronously.
- Encodings:
  - result_src: 00 ALU, 01 mem, 10 PC+4, 11 imm.
  - alu_src[0]: imm as B operand. alu_src[1]: PC as A operand.
  - alu_op: 00 none, 01 funct, 10 add, 11 sub.
- Immediate selection:
  - I: LOAD, OP-IMM, JALR.
  - S: STORE.
  - B: BRANCH.
  - U: LUI, AUIPC.
  - J: JAL.
  - Otherwise 0.
  - Sign extension is taken from instr[31] to DATA_WIDTH.
- Control per opcode:
  - reg_write: LOAD, OP, OP-IMM, JAL, JALR, LUI, AUIPC.
  - mem_write: STORE.
  - jump: JAL, JALR.
  - branch: BRANCH.
  - link_reg_ctrl: JALR.
  - alu_src[0]: LOAD, STORE, OP-IMM, AUIPC, JALR. alu_src[1]: AUIPC.
  - alu_op: 01 OP/OP-IMM; 10 LOAD/STORE/AUIPC/JALR; 11 BRANCH; else 00.
- Illegal instruction: an unknown opcode, or (REG_COUNT=16) any used rs1/rs2/rd with bit4 set.
  - illegal_c=1 and reg_write, mem_write, jump and branch are forced to 0.
  - valid_c follows valid_b.
- Register file:
  - Writes on the posedge when wr_en=1 and wr_addr!=0.
  - wr_addr>=REG_COUNT is ignored.
  - Reads of x0 return 0.
  - With BYPASS_EN=1, a read whose address equals wr_addr (nonzero) while wr_en=1 returns wr_data in the same cycle.
- Source usage:
  - rs1 is used by OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - rs2 is used by OP, STORE, BRANCH.
- Load-use hazard: hazard_b = valid_b & valid_c & (result_src_c==01) & (rd_c!=0) & ((rs1 used & rs1==rd_c) | (rs2 used & rs2==rd_c)).
- Priority per clock edge:
  - flush: valid_c=0, the six 1-bit controls cleared; other fields don't-care (keep registered values).
  - else stall: all C fields hold. Exception: if wr_en and wr_addr!=0 matches rs1_c (rs2_c), rdata1_c (rdata2_c) captures wr_data, so held operands never go stale.
  - else hazard_b: insert a bubble, same as flush. hazard_b is evaluated against the current C contents.
  - else: load C from B. Control fields are gated by valid_b (valid_b=0 => bubble).
- Latency: one cycle from B to C. Register writes are visible to B reads in the same cycle with bypass, and the next cycle without.
- Asynchronous reset mid-operation clears C immediately. No partial state survives.

Test Plan:
- Reset, then `addi x5,x0,-1` (0xFFF00293) with valid_b=1 → next cycle: valid_c=1, imm_ext_c=0xFFFFFFFF, reg_write_c=1, alu_src_c=01, alu_op_c=01, rd_c=5.
- Write port writing x3=0x1234 in the same cycle as B=`add x4,x3,x3` (BYPASS_EN=1) → rdata1_c=rdata2_c=0x1234. With BYPASS_EN=0 → both 0. Writing x0=0xFFFF, then reading x0 → 0.
- C=`lw x7,0(x1)`, B=`add x8,x7,x2` → hazard_b=1; next cycle valid_c=0, reg_write_c=0. B held → following cycle valid_c=1, rd_c=8.
- stall=1 for 3 cycles with C holding rs1_c=6, while x6 is written with 0xABCD → all fields held, rdata1_c becomes 0xABCD. stall and flush together → bubble (flush wins).
- Opcode 0x7F → illegal_c=1, all write/jump/branch controls 0. REG_COUNT=16 with `add x17,x1,x2` → illegal_c=1.
- Assert rst_n low mid-stream with valid_c=1 → all C outputs 0 immediately. Register file reads 0 after release.
